// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: FU completion handshakes in, regfile/RST strobes out.
// The arbiter takes the slave modport, the completing units the master modport.
interface wb_arbiter_if;
    logic        alu_valid;
    logic        ldst_valid;
    logic        br_valid;
    logic [4:0]  alu_rd;
    logic [4:0]  ldst_rd;
    logic [4:0]  br_rd;
    logic [31:0] alu_wdat;
    logic [31:0] ldst_wdat;
    logic [31:0] br_wdat;
    logic        alu_ready;
    logic        ldst_ready;
    logic        br_ready;
    logic        mls_valid;
    logic        gemm_valid;
    logic [3:0]  mls_md;
    logic [3:0]  gemm_md;
    logic        mls_ready;
    logic        gemm_ready;
    logic        s_rw_en;
    logic [4:0]  s_rw;
    logic [31:0] s_wdat;
    logic [1:0]  s_fu;
    logic        m_rw_en;
    logic [3:0]  m_rw;
    logic [1:0]  m_fu;

    modport slave (
        input  alu_valid, ldst_valid, br_valid,
        input  alu_rd, ldst_rd, br_rd,
        input  alu_wdat, ldst_wdat, br_wdat,
        output alu_ready, ldst_ready, br_ready,
        input  mls_valid, gemm_valid, mls_md, gemm_md,
        output mls_ready, gemm_ready,
        output s_rw_en, s_rw, s_wdat, s_fu,
        output m_rw_en, m_rw, m_fu
    );

    modport master (
        output alu_valid, ldst_valid, br_valid,
        output alu_rd, ldst_rd, br_rd,
        output alu_wdat, ldst_wdat, br_wdat,
        input  alu_ready, ldst_ready, br_ready,
        output mls_valid, gemm_valid, mls_md, gemm_md,
        input  mls_ready, gemm_ready,
        input  s_rw_en, s_rw, s_wdat, s_fu,
        input  m_rw_en, m_rw, m_fu
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding buffer per FU, round-robin grant per class.
// Scalar sources ALU/LD_ST/BRANCH = 0/1/2, matrix sources M_LD_ST/GEMM = 0/1.
module wb_arbiter (
    input logic        CLK,
    input logic        nRST,
    wb_arbiter_if.slave bus
);
    logic [2:0]  s_in_v;
    logic [4:0]  s_in_rd  [3];
    logic [31:0] s_in_dat [3];
    logic [2:0]  s_rdy;

    logic [2:0]  s_buf_v;
    logic [4:0]  s_buf_rd  [3];
    logic [31:0] s_buf_dat [3];
    logic [1:0]  s_ptr;
    logic [1:0]  s_idx;
    logic        s_any;
    logic [2:0]  s_gnt;

    logic [1:0]  m_in_v;
    logic [3:0]  m_in_md [2];
    logic [1:0]  m_rdy;

    logic [1:0]  m_buf_v;
    logic [3:0]  m_buf_md [2];
    logic        m_ptr;
    logic        m_idx;
    logic        m_any;
    logic [1:0]  m_gnt;

    assign s_in_v      = {bus.br_valid, bus.ldst_valid, bus.alu_valid};
    assign s_in_rd[0]  = bus.alu_rd;
    assign s_in_rd[1]  = bus.ldst_rd;
    assign s_in_rd[2]  = bus.br_rd;
    assign s_in_dat[0] = bus.alu_wdat;
    assign s_in_dat[1] = bus.ldst_wdat;
    assign s_in_dat[2] = bus.br_wdat;
    assign m_in_v      = {bus.gemm_valid, bus.mls_valid};
    assign m_in_md[0]  = bus.mls_md;
    assign m_in_md[1]  = bus.gemm_md;

    function automatic logic [1:0] wrap3(input logic [1:0] b, input int k);
        logic [2:0] t;
        t = {1'b0, b} + 3'(k);
        if (t >= 3'd3) t = t - 3'd3;
        return t[1:0];
    endfunction

    // Scalar round-robin: first valid buffer starting at s_ptr.
    always_comb begin
        s_idx = s_ptr;
        s_any = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            if (s_buf_v[wrap3(s_ptr, k)]) begin
                s_idx = wrap3(s_ptr, k);
                s_any = 1'b1;
            end
        end
        s_gnt = s_any ? (3'b001 << s_idx) : 3'b000;
    end

    // Matrix round-robin over two buffers.
    always_comb begin
        m_any = |m_buf_v;
        m_idx = m_buf_v[m_ptr] ? m_ptr : ~m_ptr;
        m_gnt = m_any ? (2'b01 << m_idx) : 2'b00;
    end

    // Ready from registered state only; a granted buffer can refill.
    assign s_rdy = ~s_buf_v | s_gnt;
    assign m_rdy = ~m_buf_v | m_gnt;

    assign bus.alu_ready  = s_rdy[0];
    assign bus.ldst_ready = s_rdy[1];
    assign bus.br_ready   = s_rdy[2];
    assign bus.mls_ready  = m_rdy[0];
    assign bus.gemm_ready = m_rdy[1];

    // rd == 0 drains the buffer but suppresses the strobe.
    assign bus.s_rw_en = s_any && (s_buf_rd[s_idx] != 5'd0);
    assign bus.s_rw    = s_any ? s_buf_rd[s_idx]  : 5'd0;
    assign bus.s_wdat  = s_any ? s_buf_dat[s_idx] : 32'd0;
    assign bus.s_fu    = s_any ? s_idx : 2'd0;
    assign bus.m_rw_en = m_any;
    assign bus.m_rw    = m_any ? m_buf_md[m_idx] : 4'd0;
    assign bus.m_fu    = m_any ? {1'b0, m_idx} : 2'd0;

    // Scalar buffers: capture on handshake, else clear when granted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            s_buf_v <= '0;
            s_ptr   <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                s_buf_rd[i]  <= '0;
                s_buf_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (s_in_v[i] && s_rdy[i]) begin
                    s_buf_v[i]   <= 1'b1;
                    s_buf_rd[i]  <= s_in_rd[i];
                    s_buf_dat[i] <= s_in_dat[i];
                end else if (s_gnt[i]) begin
                    s_buf_v[i] <= 1'b0;
                end
            end
            if (s_any) s_ptr <= wrap3(s_idx, 1);
        end
    end

    // Matrix buffers: same capture/drain rule, own pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_buf_v <= '0;
            m_ptr   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_buf_md[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_in_v[i] && m_rdy[i]) begin
                    m_buf_v[i]  <= 1'b1;
                    m_buf_md[i] <= m_in_md[i];
                end else if (m_gnt[i]) begin
                    m_buf_v[i] <= 1'b0;
                end
            end
            if (m_any) m_ptr <= ~m_idx;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with per-source expected-write queues.
module tb_wb_arbiter;
    logic CLK;
    logic nRST;
    wb_arbiter_if bus();

    wb_arbiter dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } exp_t;

    exp_t       sq [3][$];
    logic [3:0] mq [2][$];
    int checks = 0;
    int errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Pop the expected write for whichever source the DUT reports.
    int   sn;
    int   mn;
    exp_t se;
    always @(negedge CLK) begin
        if (nRST) begin
            if (bus.s_rw_en) begin
                sn = (bus.s_fu < 2'd3) ? sq[bus.s_fu].size() : 0;
                chk("s_write_expected", 32'(sn != 0), 32'd1);
                if (sn != 0) begin
                    se = sq[bus.s_fu].pop_front();
                    chk("s_rw_sb", 32'(bus.s_rw), 32'(se.rd));
                    chk("s_wdat_sb", bus.s_wdat, se.dat);
                end
            end
            if (bus.m_rw_en) begin
                mn = (bus.m_fu < 2'd2) ? mq[bus.m_fu[0]].size() : 0;
                chk("m_write_expected", 32'(mn != 0), 32'd1);
                if (mn != 0) begin
                    chk("m_rw_sb", 32'(bus.m_rw),
                        32'(mq[bus.m_fu[0]].pop_front()));
                end
            end
        end
    end

    initial begin
        nRST = 1'b0;
        bus.alu_valid = 0; bus.ldst_valid = 0; bus.br_valid = 0;
        bus.alu_rd = 0; bus.ldst_rd = 0; bus.br_rd = 0;
        bus.alu_wdat = 0; bus.ldst_wdat = 0; bus.br_wdat = 0;
        bus.mls_valid = 0; bus.gemm_valid = 0;
        bus.mls_md = 0; bus.gemm_md = 0;

        tick();
        chk("rst_s_rw_en", 32'(bus.s_rw_en), 0);
        chk("rst_m_rw_en", 32'(bus.m_rw_en), 0);
        chk("rst_s_wdat", bus.s_wdat, 0);
        chk("rst_alu_ready", 32'(bus.alu_ready), 1);
        chk("rst_gemm_ready", 32'(bus.gemm_ready), 1);
        nRST = 1'b1;
        tick();

        // Three scalar sources at once, pointer at reset value.
        bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_wdat = 32'h11;
        bus.ldst_valid = 1; bus.ldst_rd = 2; bus.ldst_wdat = 32'h22;
        bus.br_valid = 1; bus.br_rd = 3; bus.br_wdat = 32'h33;
        sq[0].push_back('{5'd1, 32'h11});
        sq[1].push_back('{5'd2, 32'h22});
        sq[2].push_back('{5'd3, 32'h33});
        tick();
        bus.alu_valid = 0; bus.ldst_valid = 0; bus.br_valid = 0;
        chk("tri_c1_en", 32'(bus.s_rw_en), 1);
        chk("tri_c1_rw", 32'(bus.s_rw), 1);
        chk("tri_c1_ldst_rdy", 32'(bus.ldst_ready), 0);
        chk("tri_c1_br_rdy", 32'(bus.br_ready), 0);
        tick();
        chk("tri_c2_rw", 32'(bus.s_rw), 2);
        chk("tri_c2_ldst_rdy", 32'(bus.ldst_ready), 1);
        chk("tri_c2_br_rdy", 32'(bus.br_ready), 0);
        tick();
        chk("tri_c3_rw", 32'(bus.s_rw), 3);
        chk("tri_c3_br_rdy", 32'(bus.br_ready), 1);
        tick();
        chk("tri_idle_en", 32'(bus.s_rw_en), 0);

        // Single ALU completion, one-cycle latency.
        chk("single_alu_rdy", 32'(bus.alu_ready), 1);
        bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_wdat = 32'hDEADBEEF;
        sq[0].push_back('{5'd5, 32'hDEADBEEF});
        tick();
        bus.alu_valid = 0;
        chk("single_en", 32'(bus.s_rw_en), 1);
        chk("single_rw", 32'(bus.s_rw), 5);
        chk("single_wdat", bus.s_wdat, 32'hDEADBEEF);
        chk("single_fu", 32'(bus.s_fu), 0);
        tick();
        chk("single_after_en", 32'(bus.s_rw_en), 0);
        chk("idle_s_rw", 32'(bus.s_rw), 0);
        chk("idle_s_wdat", bus.s_wdat, 0);
        chk("idle_s_fu", 32'(bus.s_fu), 0);

        // ALU streaming every cycle with no bubbles.
        for (int i = 0; i < 4; i++) begin
            chk("stream_alu_rdy", 32'(bus.alu_ready), 1);
            bus.alu_valid = 1;
            bus.alu_rd = 5'(10 + i);
            bus.alu_wdat = 32'hA000_0000 + 32'(i);
            sq[0].push_back('{5'(10 + i), 32'hA000_0000 + 32'(i)});
            tick();
            chk("stream_en", 32'(bus.s_rw_en), 1);
            chk("stream_rw", 32'(bus.s_rw), 32'(10 + i));
        end

        // LDST joins: grants alternate LDST/ALU.
        bus.alu_rd = 20; bus.alu_wdat = 32'h20;
        bus.ldst_valid = 1; bus.ldst_rd = 21; bus.ldst_wdat = 32'h21;
        sq[0].push_back('{5'd20, 32'h20});
        sq[1].push_back('{5'd21, 32'h21});
        tick();
        chk("alt_a_fu", 32'(bus.s_fu), 1);
        chk("alt_a_rw", 32'(bus.s_rw), 21);
        chk("alt_a_alu_rdy", 32'(bus.alu_ready), 0);
        bus.alu_rd = 22; bus.alu_wdat = 32'h22;
        bus.ldst_rd = 23; bus.ldst_wdat = 32'h23;
        sq[1].push_back('{5'd23, 32'h23});
        tick();
        chk("alt_b_fu", 32'(bus.s_fu), 0);
        chk("alt_b_rw", 32'(bus.s_rw), 20);
        chk("alt_b_alu_rdy", 32'(bus.alu_ready), 1);
        chk("alt_b_ldst_rdy", 32'(bus.ldst_ready), 0);
        sq[0].push_back('{5'd22, 32'h22});
        bus.ldst_rd = 25; bus.ldst_wdat = 32'h25;
        tick();
        chk("alt_c_fu", 32'(bus.s_fu), 1);
        chk("alt_c_rw", 32'(bus.s_rw), 23);
        bus.alu_valid = 0;
        sq[1].push_back('{5'd25, 32'h25});
        tick();
        bus.ldst_valid = 0;
        chk("alt_d_rw", 32'(bus.s_rw), 22);
        tick();
        chk("alt_e_rw", 32'(bus.s_rw), 25);
        chk("alt_e_fu", 32'(bus.s_fu), 1);
        tick();
        chk("alt_idle_en", 32'(bus.s_rw_en), 0);

        // BR with rd 0 ahead of ALU.
        bus.br_valid = 1; bus.br_rd = 0; bus.br_wdat = 32'h55;
        bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_wdat = 32'h66;
        sq[0].push_back('{5'd6, 32'h66});
        tick();
        bus.br_valid = 0; bus.alu_valid = 0;
        chk("rd0_en", 32'(bus.s_rw_en), 0);
        chk("rd0_br_rdy", 32'(bus.br_ready), 1);
        chk("rd0_alu_rdy", 32'(bus.alu_ready), 0);
        tick();
        chk("rd0_next_en", 32'(bus.s_rw_en), 1);
        chk("rd0_next_rw", 32'(bus.s_rw), 6);
        tick();
        chk("rd0_idle_en", 32'(bus.s_rw_en), 0);

        // Matrix pair plus concurrent scalar write.
        bus.mls_valid = 1; bus.mls_md = 7;
        bus.gemm_valid = 1; bus.gemm_md = 9;
        bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_wdat = 32'h44;
        mq[0].push_back(4'd7);
        mq[1].push_back(4'd9);
        sq[0].push_back('{5'd4, 32'h44});
        tick();
        bus.mls_valid = 0; bus.gemm_valid = 0; bus.alu_valid = 0;
        chk("mat_c1_m_en", 32'(bus.m_rw_en), 1);
        chk("mat_c1_m_rw", 32'(bus.m_rw), 7);
        chk("mat_c1_m_fu", 32'(bus.m_fu), 0);
        chk("mat_c1_s_en", 32'(bus.s_rw_en), 1);
        chk("mat_c1_s_rw", 32'(bus.s_rw), 4);
        chk("mat_c1_gemm_rdy", 32'(bus.gemm_ready), 0);
        tick();
        chk("mat_c2_m_rw", 32'(bus.m_rw), 9);
        chk("mat_c2_m_fu", 32'(bus.m_fu), 1);
        chk("mat_c2_s_en", 32'(bus.s_rw_en), 0);
        tick();
        chk("mat_idle_en", 32'(bus.m_rw_en), 0);
        chk("mat_idle_rw", 32'(bus.m_rw), 0);

        // Fill three buffers, then a half-cycle reset pulse.
        bus.alu_valid = 1; bus.alu_rd = 7; bus.alu_wdat = 32'h77;
        bus.ldst_valid = 1; bus.ldst_rd = 8; bus.ldst_wdat = 32'h88;
        bus.br_valid = 1; bus.br_rd = 9; bus.br_wdat = 32'h99;
        tick();
        bus.alu_valid = 0; bus.ldst_valid = 0; bus.br_valid = 0;
        chk("pre_rst_rw", 32'(bus.s_rw), 8);
        chk("pre_rst_alu_rdy", 32'(bus.alu_ready), 0);
        #1;
        nRST = 1'b0;
        #1;
        chk("rst_pulse_en", 32'(bus.s_rw_en), 0);
        chk("rst_pulse_rw", 32'(bus.s_rw), 0);
        chk("rst_pulse_wdat", bus.s_wdat, 0);
        #4;
        nRST = 1'b1;
        #1;
        chk("post_rst_alu_rdy", 32'(bus.alu_ready), 1);
        chk("post_rst_ldst_rdy", 32'(bus.ldst_ready), 1);
        chk("post_rst_br_rdy", 32'(bus.br_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_en", 32'(bus.s_rw_en), 0);
        end

        for (int i = 0; i < 3; i++) begin
            chk("s_queue_drained", 32'(sq[i].size()), 0);
        end
        for (int i = 0; i < 2; i++) begin
            chk("m_queue_drained", 32'(mq[i].size()), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
